// File: rtl/line_fill_buffer.sv
// Purpose: assembles one cache line from a serial memory return stream (critical word first, wrapping), with store-merge.
// Latency: line_out updates the cycle after each write; fill_done pulses WORDS+2 cycles after fill_start with no stalls.
// Backpressure: mem_ready is high only while filling; mem_valid low simply stalls the fill, nothing is dropped.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   fill_start, fill_offset        begin a fill at the given critical word index (ignored unless idle)
//   mem_valid, mem_data, mem_ready memory return beats; a beat is mem_valid & mem_ready
//   wr_en, wr_sel, wr_data         store-merge single-word write, accepted in any state
//   line_out                       assembled line, word i at [i*WORD_W +: WORD_W]
//   fill_busy                      fill in progress
//   crit_valid, crit_data          one-cycle pulse when the critical word is captured; data holds until next fill
//   fill_done                      one-cycle pulse when the line is complete
module line_fill_buffer #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 16,
  parameter int SEL_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fill_start,
  input  logic [SEL_W-1:0]         fill_offset,
  input  logic                     mem_valid,
  input  logic [WORD_W-1:0]        mem_data,
  output logic                     mem_ready,
  input  logic                     wr_en,
  input  logic [SEL_W-1:0]         wr_sel,
  input  logic [WORD_W-1:0]        wr_data,
  output logic [WORD_W*WORDS-1:0]  line_out,
  output logic                     fill_busy,
  output logic                     crit_valid,
  output logic [WORD_W-1:0]        crit_data,
  output logic                     fill_done
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                         state;
  state_t                         stateNext;
  logic [WORDS-1:0][WORD_W-1:0]   lineReg;
  logic [WORDS-1:0]               mergeMask;
  logic [SEL_W-1:0]               ptr;
  logic [SEL_W-1:0]               cnt;
  logic                           beat;

  assign line_out = lineReg;
  assign beat     = mem_valid & mem_ready;

  always_comb begin
    stateNext = state;
    mem_ready = 1'b0;
    fill_busy = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) stateNext = FILL;
      end
      FILL: begin
        mem_ready = 1'b1;
        fill_busy = 1'b1;
        if (beat && cnt == SEL_W'(WORDS-1)) stateNext = DONE;
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lineReg    <= '0;
      mergeMask  <= '0;
      ptr        <= '0;
      cnt        <= '0;
      crit_valid <= 1'b0;
      crit_data  <= '0;
      fill_done  <= 1'b0;
    end else begin
      state      <= stateNext;
      crit_valid <= 1'b0;
      // Registered off the DONE state, so the pulse lands one cycle after the last beat's state update.
      fill_done  <= (state == DONE);

      if (state == IDLE && fill_start) begin
        ptr       <= fill_offset;
        cnt       <= '0;
        mergeMask <= '0;
      end

      if (beat) begin
        // Words already written by a store keep the store data.
        if (!mergeMask[ptr]) lineReg[ptr] <= mem_data;
        ptr <= ptr + SEL_W'(1);
        cnt <= cnt + SEL_W'(1);
        if (cnt == '0) begin
          crit_valid <= 1'b1;
          // Report what the line will actually hold for the critical word.
          if (wr_en && wr_sel == ptr)  crit_data <= wr_data;
          else if (mergeMask[ptr])     crit_data <= lineReg[ptr];
          else                         crit_data <= mem_data;
        end
      end

      // Placed after the beat write so a same-cycle store to the same word wins.
      // The mask only matters for a fill in flight; an idle store is overwritten by the next fill.
      if (wr_en) begin
        lineReg[wr_sel] <= wr_data;
        if (state != IDLE) mergeMask[wr_sel] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_line_fill_buffer.sv
// Purpose: scoreboard bench for line_fill_buffer; stimulus pushes expected crit words and lines, a monitor pops on crit_valid/fill_done.
// Latency: expects fill_done 18 cycles after fill_start for zero-stall fills.
// Backpressure: stimulus only counts beats where mem_valid and mem_ready are both high.
module tb_line_fill_buffer;

  logic         clk;
  logic         rst_n;
  logic         fillStart;
  logic [3:0]   fillOffset;
  logic         memValid;
  logic [31:0]  memData;
  logic         memReady;
  logic         wrEn;
  logic [3:0]   wrSel;
  logic [31:0]  wrData;
  logic [511:0] lineOut;
  logic         fillBusy;
  logic         critValid;
  logic [31:0]  critData;
  logic         fillDone;

  typedef struct {
    logic [511:0] line;
    int           lat;
  } exp_t;

  exp_t         lineExpQ[$];
  logic [31:0]  critExpQ[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           startCyc = 0;

  line_fill_buffer #(.WORD_W(32), .WORDS(16), .SEL_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fill_start  (fillStart),
    .fill_offset (fillOffset),
    .mem_valid   (memValid),
    .mem_data    (memData),
    .mem_ready   (memReady),
    .wr_en       (wrEn),
    .wr_sel      (wrSel),
    .wr_data     (wrData),
    .line_out    (lineOut),
    .fill_busy   (fillBusy),
    .crit_valid  (critValid),
    .crit_data   (critData),
    .fill_done   (fillDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare whenever the DUT presents a critical word or a finished line.
  always @(negedge clk) begin
    if (rst_n) begin
      if (critValid) begin
        if (critExpQ.size() == 0) check("crit_unexpected", 512'(critValid), 512'(0));
        else check("crit_data", 512'(critData), 512'(critExpQ.pop_front()));
      end
      if (fillDone) begin
        if (lineExpQ.size() == 0) check("done_unexpected", 512'(fillDone), 512'(0));
        else begin
          exp_t e;
          e = lineExpQ.pop_front();
          check("line_out", lineOut, e.line);
          if (e.lat > 0) check("done_latency", 512'(cyc - startCyc), 512'(e.lat));
        end
      end
    end
  end

  // wrAt: beat index carrying a store (>=0), -1 none, -2 store in the fill_start cycle.
  task automatic runFill(input string tag, input logic [3:0] off, input logic [31:0] base,
                         input bit toggle, input int wrAt, input logic [3:0] ws,
                         input logic [31:0] wd, input int lat, input bit startMid);
    logic [15:0][31:0] expLine;
    logic [3:0]        idx;
    exp_t              e;
    int                i;
    int                guard;
    bit                phase;
    bit                beatNow;
    for (int k = 0; k < 16; k++) begin
      idx = off + 4'(k);
      expLine[idx] = base + 32'(k);
    end
    if (wrAt >= 0) expLine[ws] = wd;
    e.line = expLine;
    e.lat  = lat;
    lineExpQ.push_back(e);
    critExpQ.push_back(base);

    fillStart  = 1'b1;
    fillOffset = off;
    if (wrAt == -2) begin
      wrEn   = 1'b1;
      wrSel  = ws;
      wrData = wd;
    end
    startCyc = cyc;
    @(posedge clk); #1;
    fillStart = 1'b0;
    wrEn      = 1'b0;
    check({tag, "_busy"}, 512'(fillBusy), 512'(1));
    if (wrAt == -2) check({tag, "_idle_store"}, 512'(lineOut[ws*32 +: 32]), 512'(wd));

    i = 0; guard = 0; phase = 1'b0;
    while (i < 16 && guard < 100) begin
      phase      = toggle ? ~phase : 1'b1;
      memValid   = phase;
      memData    = base + 32'(i);
      wrEn       = (wrAt >= 0 && i == wrAt && phase);
      wrSel      = ws;
      wrData     = wd;
      fillStart  = startMid && i == 4;
      fillOffset = startMid ? 4'd9 : off;
      beatNow    = memValid & memReady;
      @(posedge clk); #1;
      if (beatNow) i++;
      guard++;
    end
    memValid  = 1'b0;
    wrEn      = 1'b0;
    fillStart = 1'b0;
    check({tag, "_beats"}, 512'(i), 512'(16));

    guard = 0;
    while (lineExpQ.size() != 0 && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_done_seen"}, 512'(lineExpQ.size()), 512'(0));
    check({tag, "_idle_after"}, 512'(fillBusy), 512'(0));
  endtask

  initial begin
    rst_n = 1'b0; fillStart = 1'b0; fillOffset = '0; memValid = 1'b0; memData = '0;
    wrEn = 1'b0; wrSel = '0; wrData = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_line", lineOut, 512'(0));
    check("rst_ready", 512'(memReady), 512'(0));
    check("rst_busy", 512'(fillBusy), 512'(0));
    check("rst_crit_valid", 512'(critValid), 512'(0));
    check("rst_crit_data", 512'(critData), 512'(0));
    check("rst_done", 512'(fillDone), 512'(0));

    // T1: aligned, back-to-back, latency checked
    runFill("t1", 4'd0, 32'h100, 1'b0, -1, 4'd0, 32'h0, 18, 1'b0);
    // T2: wrapping critical-word-first
    runFill("t2", 4'd13, 32'h200, 1'b0, -1, 4'd0, 32'h0, 18, 1'b0);
    // T3: store to word 5 before its beat arrives
    runFill("t3", 4'd0, 32'h300, 1'b0, 2, 4'd5, 32'hDEAD, 18, 1'b0);
    // T4: store and beat to word 7 in the same cycle
    runFill("t4", 4'd0, 32'h400, 1'b0, 7, 4'd7, 32'hCAFE, 18, 1'b0);
    check("t4_mask7", 512'(dut.mergeMask[7]), 512'(1));
    // T5: mem_valid toggling, stray fill_start mid-fill
    runFill("t5", 4'd6, 32'h500, 1'b1, -1, 4'd0, 32'h0, 0, 1'b1);
    // Store in the fill_start cycle: lands, then mask clears, memory overwrites it
    runFill("t7", 4'd0, 32'h700, 1'b0, -2, 4'd2, 32'hBEEF, 18, 1'b0);

    // T6: reset after 8 beats
    critExpQ.push_back(32'h600);
    fillStart = 1'b1; fillOffset = 4'd3;
    @(posedge clk); #1;
    fillStart = 1'b0;
    for (int k = 0; k < 8; k++) begin
      memValid = 1'b1;
      memData  = 32'h600 + 32'(k);
      @(posedge clk); #1;
    end
    memValid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("t6_line", lineOut, 512'(0));
    check("t6_ready", 512'(memReady), 512'(0));
    check("t6_busy", 512'(fillBusy), 512'(0));
    check("t6_crit_seen", 512'(critExpQ.size()), 512'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    runFill("t6b", 4'd9, 32'h800, 1'b0, -1, 4'd0, 32'h0, 18, 1'b0);

    check("final_crit_q", 512'(critExpQ.size()), 512'(0));
    check("final_line_q", 512'(lineExpQ.size()), 512'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
